// File: rtl/vector_add_stream_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vector_add_stream_unit
//  Purpose  : Streams one integer add-family vector instruction (vadd, vsub,
//             vrsub, vadc, vsbc, vmadc, vmsbc) over vl elements. Operands
//             arrive as DATA_WIDTH-bit beats; results leave through a
//             registered valid/ready stage. Mask ops gather their
//             carry/borrow bits across beats and return one packed mask beat.
//  Ports    :
//    clk, rst_n           - clock, asynchronous active-low reset
//    start                - launch request (sampled in IDLE only)
//    op[2:0]              - 0 ADD 1 SUB 2 RSUB 3 ADC 4 SBC 5 MADC 6 MSBC (7=ADD)
//    use_carry            - MADC/MSBC: include v0 carry/borrow-in
//    sew[1:0]             - element width 8/16/32/64
//    vl[VL_WIDTH-1:0]     - element count (clamped to MAX_VL)
//    busy                 - FSM not idle
//    in_valid / in_ready  - operand beat handshake (vs2, vs1, v0)
//    out_valid / out_ready- result handshake (vd, out_last)
//    done                 - one-cycle completion pulse
//  Revision : 1.0  initial release
// ============================================================================
module vector_add_stream_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_VL     = 64,
    parameter int VL_WIDTH   = $clog2(MAX_VL) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2:0]              op,
    input  logic                    use_carry,
    input  logic [1:0]              sew,
    input  logic [VL_WIDTH-1:0]     vl,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   vs2,
    input  logic [DATA_WIDTH-1:0]   vs1,
    input  logic [DATA_WIDTH/8-1:0] v0,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   vd,
    output logic                    out_last,
    output logic                    done
);

    localparam int NV0   = DATA_WIDTH / 8;
    // Element counter must hold the start index of a beat past the last one.
    localparam int CNT_W = $clog2(MAX_VL + NV0) + 2;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_RSUB = 3'd2;
    localparam logic [2:0] OP_ADC  = 3'd3;
    localparam logic [2:0] OP_SBC  = 3'd4;
    localparam logic [2:0] OP_MADC = 3'd5;
    localparam logic [2:0] OP_MSBC = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MASK_OUT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic                    use_carry_q, use_carry_d;
    logic [1:0]              sew_q, sew_d;
    logic [VL_WIDTH-1:0]     vl_q, vl_d;
    logic [CNT_W-1:0]        elem_cnt_q, elem_cnt_d;
    logic [MAX_VL-1:0]       mask_q, mask_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0]   vd_q, vd_d;
    logic                    done_q, done_d;

    logic [VL_WIDTH-1:0]     vl_clamped;
    logic [CNT_W-1:0]        vl_ext;
    logic [CNT_W-1:0]        e_per_beat;
    logic [4*DATA_WIDTH-1:0] res_all;
    logic [4*NV0-1:0]        cout_all;
    logic [DATA_WIDTH-1:0]   res_sel;
    logic [NV0-1:0]          cout_sel;
    logic [MAX_VL-1:0]       mask_new;
    logic                    is_mask_op;
    logic                    inputs_left;
    logic                    last_beat;
    logic                    accept;

    assign vl_clamped = (vl > VL_WIDTH'(MAX_VL)) ? VL_WIDTH'(MAX_VL) : vl;
    assign vl_ext     = CNT_W'(vl_q);

    // ------------------------------------------------------------------
    // Per-element datapath, built once per element width. Every element
    // computes an (SEW+1)-bit result so bit SEW is the carry/borrow-out.
    // Tail elements (global index >= vl) become all-ones data / zero mask.
    // ------------------------------------------------------------------
    for (genvar s = 0; s < 4; s++) begin : g_sew
        localparam int W  = 8 << s;
        localparam int NE = DATA_WIDTH / W;

        for (genvar e = 0; e < NE; e++) begin : g_elem
            logic [W:0] a_x;
            logic [W:0] b_x;
            logic [W:0] c_x;
            logic [W:0] sum;
            logic       tail;

            always_comb begin
                a_x = {1'b0, vs2[e*W +: W]};
                b_x = {1'b0, vs1[e*W +: W]};
                c_x = {{W{1'b0}}, v0[e]};
                sum = a_x + b_x;
                case (op_q)
                    OP_SUB:  sum = a_x - b_x;
                    OP_RSUB: sum = b_x - a_x;
                    OP_ADC:  sum = a_x + b_x + c_x;
                    OP_SBC:  sum = a_x - b_x - c_x;
                    OP_MADC: sum = a_x + b_x + (use_carry_q ? c_x : '0);
                    OP_MSBC: sum = a_x - b_x - (use_carry_q ? c_x : '0);
                    default: sum = a_x + b_x;
                endcase
            end

            assign tail = (elem_cnt_q + CNT_W'(e)) >= vl_ext;
            assign res_all[s*DATA_WIDTH + e*W +: W] = tail ? {W{1'b1}} : sum[W-1:0];
            assign cout_all[s*NV0 + e]              = ~tail & sum[W];
        end

        if (NE < NV0) begin : g_pad
            assign cout_all[s*NV0 + NE +: NV0 - NE] = '0;
        end
    end

    always_comb begin
        res_sel    = '0;
        cout_sel   = '0;
        e_per_beat = '0;
        case (sew_q)
            2'd0: begin
                res_sel    = res_all[0*DATA_WIDTH +: DATA_WIDTH];
                cout_sel   = cout_all[0*NV0 +: NV0];
                e_per_beat = CNT_W'(DATA_WIDTH / 8);
            end
            2'd1: begin
                res_sel    = res_all[1*DATA_WIDTH +: DATA_WIDTH];
                cout_sel   = cout_all[1*NV0 +: NV0];
                e_per_beat = CNT_W'(DATA_WIDTH / 16);
            end
            2'd2: begin
                res_sel    = res_all[2*DATA_WIDTH +: DATA_WIDTH];
                cout_sel   = cout_all[2*NV0 +: NV0];
                e_per_beat = CNT_W'(DATA_WIDTH / 32);
            end
            default: begin
                res_sel    = res_all[3*DATA_WIDTH +: DATA_WIDTH];
                cout_sel   = cout_all[3*NV0 +: NV0];
                e_per_beat = CNT_W'(DATA_WIDTH / 64);
            end
        endcase
    end

    // Carry bits of this beat land at mask bit elem_cnt + i; bits that fall
    // beyond MAX_VL are tail and drop off in the truncation.
    assign mask_new = mask_q | MAX_VL'({{MAX_VL{1'b0}}, cout_sel} << elem_cnt_q);

    assign is_mask_op  = (op_q == OP_MADC) || (op_q == OP_MSBC);
    assign inputs_left = elem_cnt_q < vl_ext;
    assign last_beat   = (elem_cnt_q + e_per_beat) >= vl_ext;

    // Arithmetic ops may only take a beat if the output register is free or
    // draining this cycle; mask ops never occupy it while in RUN.
    assign in_ready = (state_q == S_RUN) && inputs_left &&
                      (is_mask_op || !out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        use_carry_d = use_carry_q;
        sew_d       = sew_q;
        vl_d        = vl_q;
        elem_cnt_d  = elem_cnt_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        vd_d        = vd_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d        = op;
                    use_carry_d = use_carry;
                    sew_d       = sew;
                    vl_d        = vl_clamped;
                    elem_cnt_d  = '0;
                    mask_d      = '0;
                    if (vl_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (accept) begin
                    elem_cnt_d = elem_cnt_q + e_per_beat;
                    if (is_mask_op) begin
                        mask_d = mask_new;
                        if (last_beat) begin
                            state_d     = S_MASK_OUT;
                            out_valid_d = 1'b1;
                            out_last_d  = 1'b1;
                            vd_d        = DATA_WIDTH'(mask_new);
                        end
                    end else begin
                        out_valid_d = 1'b1;
                        out_last_d  = last_beat;
                        vd_d        = res_sel;
                    end
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_MASK_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            use_carry_q <= 1'b0;
            sew_q       <= '0;
            vl_q        <= '0;
            elem_cnt_q  <= '0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            vd_q        <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            use_carry_q <= use_carry_d;
            sew_q       <= sew_d;
            vl_q        <= vl_d;
            elem_cnt_q  <= elem_cnt_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            vd_q        <= vd_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign vd        = vd_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_add_stream_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vector_add_stream_unit
//  Purpose  : Directed, scoreboard-checked bench for vector_add_stream_unit.
//             Stimulus pushes hand-computed result beats into a queue; a
//             monitor pops and compares on every output handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vector_add_stream_unit;

    localparam int DW = 64;
    localparam int MV = 64;
    localparam int VW = 7;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [2:0]    op;
    logic          use_carry;
    logic [1:0]    sew;
    logic [VW-1:0] vl;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] vs2;
    logic [DW-1:0] vs1;
    logic [7:0]    v0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] vd;
    logic          out_last;
    logic          done;

    vector_add_stream_unit #(
        .DATA_WIDTH (DW),
        .MAX_VL     (MV),
        .VL_WIDTH   (VW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .use_carry (use_carry),
        .sew       (sew),
        .vl        (vl),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vs2       (vs2),
        .vs1       (vs1),
        .v0        (v0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .vd        (vd),
        .out_last  (out_last),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt   = 0;
    int   pass_cnt  = 0;
    int   done_cnt  = 0;
    int   stall_cnt = 0;
    logic ov_seen   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic push(input logic [63:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Monitor: compares on handshake, checks hold behaviour under stall.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_beat: got vd=%h, required no beat", vd);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("vd", vd, e.data);
                    check("out_last", {63'd0, out_last}, {63'd0, e.last});
                end
            end else if (out_valid && !out_ready && exp_q.size() != 0) begin
                stall_cnt++;
                check("vd_held", vd, exp_q[0].data);
                check("in_ready_stall", {63'd0, in_ready}, 64'd0);
            end
            if (out_valid) ov_seen = 1'b1;
            if (done) done_cnt++;
        end
    end

    task automatic start_instr(input logic [2:0] o, input logic uc,
                               input logic [1:0] s, input logic [VW-1:0] l);
        op = o; use_carry = uc; sew = s; vl = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input logic [7:0] c);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        vs2 = a; vs1 = b; v0 = c; in_valid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            chk_cnt++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        check(name, 64'(done_cnt), 64'(target));
        check({name, "_busy"}, {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200us");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; use_carry = 1'b0; sew = '0; vl = '0;
        in_valid = 1'b0; vs2 = '0; vs1 = '0; v0 = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {59'd0, busy, in_ready, out_valid, out_last, done}, 64'd0);
        check("reset_vd", vd, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD, SEW=8: 0xFF + 0x01 wraps to zero in every element
        push(64'h0, 1'b1);
        start_instr(3'd0, 1'b0, 2'd0, 7'd8);
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101, 8'h00);
        wait_done(1, "add8_done");

        // SUB, SEW=16, vl=5: 1-2 = 0xFFFF, second beat tail all-ones
        push(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        push(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        start_instr(3'd1, 1'b0, 2'd1, 7'd5);
        send_beat(64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002, 8'h00);
        send_beat(64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002, 8'h00);
        wait_done(2, "sub16_done");

        // ADD, SEW=16, vl=5: tail visible against real data
        push(64'h0003_0003_0003_0003, 1'b0);
        push(64'hFFFF_FFFF_FFFF_0003, 1'b1);
        start_instr(3'd0, 1'b0, 2'd1, 7'd5);
        send_beat(64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002, 8'h00);
        send_beat(64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002, 8'h00);
        wait_done(3, "add16_tail_done");

        // RSUB, SEW=8: 3-1 = 2
        push(64'h0202_0202_0202_0202, 1'b1);
        start_instr(3'd2, 1'b0, 2'd0, 7'd8);
        send_beat(64'h0101_0101_0101_0101, 64'h0303_0303_0303_0303, 8'h00);
        wait_done(4, "rsub_done");

        // SBC, SEW=16: 0x10-1-v0[i], v0=0101b
        push(64'h000F_000E_000F_000E, 1'b1);
        start_instr(3'd4, 1'b0, 2'd1, 7'd4);
        send_beat(64'h0010_0010_0010_0010, 64'h0001_0001_0001_0001, 8'h05);
        wait_done(5, "sbc_done");

        // ADC, SEW=32: FFFFFFFF+0+1=0, 5+6+1=0xC
        push(64'h0000_000C_0000_0000, 1'b1);
        start_instr(3'd3, 1'b0, 2'd2, 7'd2);
        send_beat({32'h5, 32'hFFFF_FFFF}, {32'h6, 32'h0}, 8'h03);
        wait_done(6, "adc_done");

        // MADC with carry-in, SEW=32, vl=4 -> mask 0101b
        push(64'h5, 1'b1);
        start_instr(3'd5, 1'b1, 2'd2, 7'd4);
        send_beat({32'h1, 32'hFFFF_FFFF}, {32'h1, 32'h0}, 8'h01);
        send_beat({32'h0, 32'h8000_0000}, {32'h0, 32'h8000_0000}, 8'h02);
        wait_done(7, "madc_done");

        // MSBC without borrow-in (v0 must be ignored), SEW=64, vl=3 -> 101b
        push(64'h5, 1'b1);
        start_instr(3'd6, 1'b0, 2'd3, 7'd3);
        send_beat(64'd1, 64'd2, 8'h01);
        send_beat(64'd5, 64'd5, 8'h01);
        send_beat(64'd0, 64'd1, 8'h01);
        wait_done(8, "msbc_done");

        // Backpressure: out_ready low for 3 cycles mid-stream
        stall_cnt = 0;
        push(64'd11, 1'b0);
        push(64'd22, 1'b0);
        push(64'd33, 1'b0);
        push(64'd44, 1'b1);
        start_instr(3'd0, 1'b0, 2'd3, 7'd4);
        fork
            begin
                send_beat(64'd10, 64'd1, 8'h00);
                send_beat(64'd20, 64'd2, 8'h00);
                send_beat(64'd30, 64'd3, 8'h00);
                send_beat(64'd40, 64'd4, 8'h00);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_done(9, "bp_done");
        check("bp_stall_cycles", 64'(stall_cnt), 64'd3);

        // vl = 0: done pulse, no output beat
        ov_seen = 1'b0;
        start_instr(3'd0, 1'b0, 2'd0, 7'd0);
        wait_done(10, "vl0_done");
        check("vl0_no_valid", {63'd0, ov_seen}, 64'd0);

        // Reset in RUN with a pending output beat
        start_instr(3'd0, 1'b0, 2'd0, 7'd16);
        send_beat(64'h1111_1111_1111_1111, 64'h0101_0101_0101_0101, 8'h00);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {59'd0, busy, in_ready, out_valid, out_last, done}, 64'd0);
        check("rst_mid_vd", vd, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_no_done", 64'(done_cnt), 64'd10);

        // Normal instruction after the abort
        push(64'h0, 1'b1);
        start_instr(3'd0, 1'b0, 2'd0, 7'd8);
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101, 8'h00);
        wait_done(11, "post_rst_done");

        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
